rom_ctrl_exp_digest_loader: RTL and testbench



---
 rtl/rom_ctrl_pkg.sv | 28 ++
 rtl/prim_count.sv | 43 ++++
 rtl/prim_sparse_fsm_flop.sv | 26 ++
 rtl/rom_ctrl_exp_digest_loader.sv | 156 +++++++++++++++
 tb/tb_rom_ctrl_exp_digest_loader.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared definitions for the ROM controller expected-digest loader.
// Holds the loader FSM encoding, the digest word width and small helper
// functions for derived widths and the digest base address.
package rom_ctrl_pkg;

    localparam int DigestWordW = 32;
    localparam int StateW      = 5;

    // Sparse encoding: every pair of codewords differs in at least 3 bits,
    // and no codeword is all-zeros or all-ones.
    typedef enum logic [StateW-1:0] {
        StIdle     = 5'b00111,
        StReading  = 5'b11001,
        StDraining = 5'b01100,
        StDone     = 5'b10010
    } state_e;

    // Bits needed to represent the values 0 .. value-1 (minimum 1).
    function automatic int vbits(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // The digest occupies the top num_words locations of the ROM.
    function automatic int digest_base_addr(input int rom_depth, input int num_words);
        return rom_depth - num_words;
    endfunction

endpackage

// File: rtl/prim_count.sv
// Redundant up-counter: a primary up-count and a shadow down-count kept as
// the bitwise complement of the primary. Any disagreement flags err_o.
// Ports: clk_i/rst_i (sync, active-high), incr_en_i advances by Step,
// cnt_o is the primary count, err_o reports a copy mismatch.
module prim_count #(
    parameter int Width = 4,
    parameter int Step  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             incr_en_i,
    output logic [Width-1:0] cnt_o,
    output logic             err_o
);

    localparam logic [Width-1:0] StepW = Width'(Step);

    logic [Width-1:0] up_q, up_d;
    logic [Width-1:0] dn_q, dn_d;

    always_comb begin
        up_d = up_q;
        dn_d = dn_q;
        if (incr_en_i) begin
            up_d = up_q + StepW;
            dn_d = dn_q - StepW;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            up_q <= '0;
            dn_q <= '1;
        end else begin
            up_q <= up_d;
            dn_q <= dn_d;
        end
    end

    assign cnt_o = up_q;
    assign err_o = (up_q != ~dn_q);

endmodule

// File: rtl/prim_sparse_fsm_flop.sv
// State register for sparse-encoded FSMs. Kept as a distinct primitive so
// the encoded state bits stay a recognisable, untouched register.
// Ports: clk_i/rst_i (sync, active-high), state_i next state, state_o current.
module prim_sparse_fsm_flop #(
    parameter int               Width      = 5,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] state_i,
    output logic [Width-1:0] state_o
);

    logic [Width-1:0] state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ResetValue;
        end else begin
            state_q <= state_i;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/rom_ctrl_exp_digest_loader.sv
// Loads the expected digest from the top NumWords ROM locations into
// exp_digest_o (word 0 in the LSBs) with one read outstanding at a time.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             pulse starting a load
//   rom_req_o/addr_o    read request and word address
//   rom_gnt_i           request accepted
//   rom_rvalid_i/rdata  read response
//   exp_digest_o        assembled digest
//   done_o              sticky load-complete flag
//   alert_o             fatal consistency alert
module rom_ctrl_exp_digest_loader
    import rom_ctrl_pkg::*;
#(
    parameter  int NumWords = 8,
    parameter  int RomDepth = 8192,
    localparam int AW       = $clog2(RomDepth),
    localparam int CW       = vbits(NumWords + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    output logic                            rom_req_o,
    output logic [AW-1:0]                   rom_addr_o,
    input  logic                            rom_gnt_i,
    input  logic                            rom_rvalid_i,
    input  logic [DigestWordW-1:0]          rom_rdata_i,
    output logic [NumWords*DigestWordW-1:0] exp_digest_o,
    output logic                            done_o,
    output logic                            alert_o
);

    localparam logic [AW-1:0] BaseAddr  = AW'(digest_base_addr(RomDepth, NumWords));
    localparam logic [CW-1:0] NumWordsC = CW'(NumWords);
    localparam logic [CW-1:0] LastIdx   = CW'(NumWords - 1);

    logic [StateW-1:0]      state_raw;
    state_e                 state_q, state_d;
    logic                   pending_q, pending_d;
    logic [CW-1:0]          req_cnt, rsp_cnt;
    logic                   req_cnt_err, rsp_cnt_err;
    logic                   req_fire, rsp_fire, req;
    logic                   state_invalid;
    logic [DigestWordW-1:0] digest_q [NumWords];

    prim_sparse_fsm_flop #(
        .Width      (StateW),
        .ResetValue (StIdle)
    ) u_state_regs (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .state_i (state_d),
        .state_o (state_raw)
    );

    assign state_q = state_e'(state_raw);

    prim_count #(.Width(CW), .Step(1)) u_req_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .incr_en_i (req_fire),
        .cnt_o     (req_cnt),
        .err_o     (req_cnt_err)
    );

    prim_count #(.Width(CW), .Step(1)) u_rsp_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .incr_en_i (rsp_fire),
        .cnt_o     (rsp_cnt),
        .err_o     (rsp_cnt_err)
    );

    // Responses without an outstanding read are dropped (alert only).
    assign rsp_fire = rom_rvalid_i && pending_q;

    always_comb begin
        state_d    = state_q;
        req        = 1'b0;
        req_fire   = 1'b0;
        rom_addr_o = '0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StReading;
                end
            end
            StReading: begin
                // pending_q is still set in the cycle its rvalid arrives, so the
                // next request always starts one cycle after the response.
                req        = !pending_q;
                rom_addr_o = req ? (BaseAddr + AW'(req_cnt)) : '0;
                if (req && rom_gnt_i) begin
                    req_fire = 1'b1;
                    if (req_cnt == LastIdx) begin
                        state_d = StDraining;
                    end
                end
            end
            StDraining: begin
                if (rsp_fire && rsp_cnt == LastIdx) begin
                    state_d = StDone;
                end
            end
            StDone: begin
            end
            default: begin
                // Invalid encoding: hold it so the alert stays asserted.
            end
        endcase
    end

    assign rom_req_o = req;

    always_comb begin
        pending_d = pending_q;
        if (rsp_fire) begin
            pending_d = 1'b0;
        end else if (req_fire) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    for (genvar gi = 0; gi < NumWords; gi++) begin : g_word
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                digest_q[gi] <= '0;
            end else if (rsp_fire && rsp_cnt == CW'(gi)) begin
                digest_q[gi] <= rom_rdata_i;
            end
        end
        assign exp_digest_o[gi*DigestWordW +: DigestWordW] = digest_q[gi];
    end

    assign done_o = (state_q == StDone);

    assign state_invalid = !(state_q inside {StIdle, StReading, StDraining, StDone});

    assign alert_o = state_invalid
                   | (start_i && state_q != StIdle)
                   | (rom_rvalid_i && !pending_q)
                   | (state_q == StIdle && (req_cnt != '0 || rsp_cnt != '0))
                   | (state_q == StDone && (req_cnt != NumWordsC || rsp_cnt != NumWordsC))
                   | (req_cnt < rsp_cnt)
                   | req_cnt_err
                   | rsp_cnt_err;

endmodule

// File: tb/tb_rom_ctrl_exp_digest_loader.sv
module tb_rom_ctrl_exp_digest_loader;
    import rom_ctrl_pkg::*;

    localparam int NumWords = 8;
    localparam int RomDepth = 8192;
    localparam int AW       = 13;
    localparam int DW       = NumWords * 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          rom_req_o;
    logic [AW-1:0] rom_addr_o;
    logic          rom_gnt_i;
    logic          rom_rvalid_i;
    logic [31:0]   rom_rdata_i;
    logic [DW-1:0] exp_digest_o;
    logic          done_o;
    logic          alert_o;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues filled by the stimulus, drained by the monitor.
    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_dig_q  [$];
    int            exp_lat_q  [$];

    // ROM responder controls.
    int          gnt_delay [NumWords];
    int          rv_delay  [NumWords];
    int          word_idx = 0;
    int          gnt_cnt;
    int          rv_wait;
    logic [31:0] rv_data;
    bit          rom_abort     = 1'b0;
    bit          inject_rv     = 1'b0;
    bit          alert_allowed = 1'b0;

    int cyc = 0;
    int start_cyc = 0;

    always #5 clk_i = ~clk_i;

    rom_ctrl_exp_digest_loader #(
        .NumWords (NumWords),
        .RomDepth (RomDepth)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .rom_req_o    (rom_req_o),
        .rom_addr_o   (rom_addr_o),
        .rom_gnt_i    (rom_gnt_i),
        .rom_rvalid_i (rom_rvalid_i),
        .rom_rdata_i  (rom_rdata_i),
        .exp_digest_o (exp_digest_o),
        .done_o       (done_o),
        .alert_o      (alert_o)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    // ROM model: rdata = 0xA0 + address, per-word grant/response delays.
    initial begin
        rom_gnt_i    = 1'b0;
        rom_rvalid_i = 1'b0;
        rom_rdata_i  = '0;
        rv_wait      = -1;
        gnt_cnt      = 0;
        rv_data      = '0;
        forever begin
            @(negedge clk_i);
            rom_gnt_i    = 1'b0;
            rom_rvalid_i = 1'b0;
            rom_rdata_i  = '0;
            if (rom_abort) begin
                rv_wait = -1;
                gnt_cnt = 0;
            end else begin
                if (inject_rv) begin
                    rom_rvalid_i = 1'b1;
                    rom_rdata_i  = 32'hDEADBEEF;
                    inject_rv    = 1'b0;
                end else if (rv_wait == 0) begin
                    rom_rvalid_i = 1'b1;
                    rom_rdata_i  = rv_data;
                    rv_wait      = -1;
                end else if (rv_wait > 0) begin
                    rv_wait--;
                end
                if (rom_req_o) begin
                    if (gnt_cnt < gnt_delay[word_idx]) begin
                        gnt_cnt++;
                    end else begin
                        rom_gnt_i = 1'b1;
                        rv_data   = 32'hA0 + 32'(rom_addr_o);
                        rv_wait   = rv_delay[word_idx];
                        gnt_cnt   = 0;
                        if (word_idx < NumWords - 1) word_idx++;
                    end
                end
            end
        end
    end

    // Monitor: compares addresses, idle address, alert and done-time digest.
    initial begin
        logic done_prev;
        int   lat;
        done_prev = 1'b0;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_i) begin
                done_prev = 1'b0;
            end else begin
                if (rom_req_o) begin
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: addr %0d with no request expected", rom_addr_o);
                    end else begin
                        chk("req_addr", DW'(rom_addr_o), DW'(exp_addr_q[0]));
                        if (rom_gnt_i) void'(exp_addr_q.pop_front());
                    end
                end else begin
                    chk("addr_when_idle", DW'(rom_addr_o), '0);
                end
                if (!alert_allowed) chk("alert_quiet", DW'(alert_o), '0);
                if (done_o && !done_prev) begin
                    if (exp_dig_q.size() == 0 || exp_lat_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done_o rose with no load expected");
                    end else begin
                        lat = cyc - start_cyc + 1;
                        chk("digest", exp_digest_o, exp_dig_q.pop_front());
                        chk("done_latency", DW'(lat), DW'(exp_lat_q.pop_front()));
                    end
                end
                done_prev = done_o;
            end
        end
    end

    task automatic start_load(input int lat);
        logic [DW-1:0] dig;
        dig = '0;
        for (int i = 0; i < NumWords; i++) begin
            exp_addr_q.push_back(13'd8184 + AW'(i));
            dig[32*i +: 32] = 32'h0000_2098 + 32'(i);  // 0xA0 + 8184 + i
        end
        exp_dig_q.push_back(dig);
        exp_lat_q.push_back(lat);
        word_idx = 0;
        @(negedge clk_i);
        start_i   = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (!done_o && n < max) begin
            @(negedge clk_i);
            n++;
        end
        #3;
        checks++;
        if (!done_o) begin
            errors++;
            $display("FAIL done_timeout: done_o=%0b expected 1 within %0d cycles", done_o, max);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i     = 1'b1;
        rom_abort = 1'b1;
        start_i   = 1'b0;
        exp_addr_q.delete();
        exp_dig_q.delete();
        exp_lat_q.delete();
        repeat (2) @(negedge clk_i);
        rst_i     = 1'b0;
        rom_abort = 1'b0;
    endtask

    initial begin
        rst_i     = 1'b1;
        start_i   = 1'b0;
        rom_abort = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i     = 1'b0;
        rom_abort = 1'b0;
        #1;
        chk("rst_req", DW'(rom_req_o), '0);
        chk("rst_addr", DW'(rom_addr_o), '0);
        chk("rst_digest", exp_digest_o, '0);
        chk("rst_done", DW'(done_o), '0);
        chk("rst_alert", DW'(alert_o), '0);
        chk("rst_state", DW'(dut.state_q), DW'(StIdle));

        // Spurious response while idle.
        @(posedge clk_i);
        #1;
        alert_allowed = 1'b1;
        inject_rv     = 1'b1;
        @(negedge clk_i);
        #1;
        chk("spurious_alert", DW'(alert_o), DW'(1'b1));
        @(negedge clk_i);
        #1;
        chk("spurious_alert_clear", DW'(alert_o), '0);
        chk("spurious_digest", exp_digest_o, '0);
        chk("spurious_req_cnt", DW'(dut.req_cnt), '0);
        chk("spurious_rsp_cnt", DW'(dut.rsp_cnt), '0);
        alert_allowed = 1'b0;

        // Back-to-back load: 2*8+1 cycles.
        start_load(17);
        wait_done(60);
        do_reset();

        // Grant held off 3 cycles on word 2, response 3 cycles late on word 5.
        gnt_delay[2] = 3;
        rv_delay[5]  = 3;
        start_load(23);
        wait_done(80);
        gnt_delay[2] = 0;
        rv_delay[5]  = 0;
        do_reset();

        // Second start after three responses.
        start_load(17);
        repeat (6) @(negedge clk_i);
        alert_allowed = 1'b1;
        start_i       = 1'b1;
        #1;
        chk("restart_alert", DW'(alert_o), DW'(1'b1));
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        chk("restart_alert_clear", DW'(alert_o), '0);
        alert_allowed = 1'b0;
        wait_done(60);
        do_reset();

        // Reset after four of eight responses.
        start_load(17);
        repeat (8) @(negedge clk_i);
        chk("mid_rsp_cnt", DW'(dut.rsp_cnt), DW'(4));
        rst_i     = 1'b1;
        rom_abort = 1'b1;
        exp_addr_q.delete();
        exp_dig_q.delete();
        exp_lat_q.delete();
        @(negedge clk_i);
        #1;
        chk("midrst_req", DW'(rom_req_o), '0);
        chk("midrst_addr", DW'(rom_addr_o), '0);
        chk("midrst_digest", exp_digest_o, '0);
        chk("midrst_done", DW'(done_o), '0);
        chk("midrst_alert", DW'(alert_o), '0);
        chk("midrst_state", DW'(dut.state_q), DW'(StIdle));
        @(negedge clk_i);
        rst_i     = 1'b0;
        rom_abort = 1'b0;
        start_load(17);
        wait_done(60);

        // Response counter disturbed while done.
        @(negedge clk_i);
        alert_allowed = 1'b1;
        force dut.rsp_cnt = 4'd5;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rsp_forced_alert", DW'(alert_o), DW'(1'b1));
            @(negedge clk_i);
        end
        release dut.rsp_cnt;
        #1;
        chk("rsp_released_alert", DW'(alert_o), '0);
        alert_allowed = 1'b0;

        // State register driven to a non-codeword.
        @(negedge clk_i);
        alert_allowed = 1'b1;
        force dut.state_q = state_e'(5'b11111);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bad_state_alert", DW'(alert_o), DW'(1'b1));
            chk("bad_state_req", DW'(rom_req_o), '0);
            @(negedge clk_i);
        end
        release dut.state_q;
        #1;
        chk("bad_state_held_alert", DW'(alert_o), DW'(1'b1));
        do_reset();
        #1;
        chk("final_alert", DW'(alert_o), '0);
        chk("final_state", DW'(dut.state_q), DW'(StIdle));
        alert_allowed = 1'b0;

        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
